// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: a ROM line of four 32-bit words tagged with its line base.
// Pure declarations, no logic of its own.
package fetch_pkg;

    localparam int LINE_WORDS = 4;
    localparam int LINE_BYTES = 16;
    localparam int OFF_W      = 2;

    typedef struct packed {
        logic [27:0]  base;
        logic [127:0] data;
    } fetch_line_t;

    function automatic logic [31:0] line_word(input logic [127:0] data, input logic [OFF_W-1:0] off);
        return data[{off, 5'b00000} +: 32];
    endfunction

endpackage

// File: rtl/line_fifo.sv
// Circular buffer of fetch lines; push writes at the tail, pop retires the head, flush empties it.
// Single-cycle update; push is ignored when full, pop when empty, both when flushing.
module line_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  fetch_line_t              push_dat_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output fetch_line_t              head_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

    fetch_line_t      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset: an entry is only ever read after being written.
    always_ff @(posedge clk) begin
        if (!rst && do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch front end: one ROM line per cycle into a line FIFO, one instruction per cycle out to dispatch.
// Zero-latency output from the head; fetch stalls when the FIFO is full; a redirect flushes everything.
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic         clk,
    input  logic         rst,
    output logic [31:0]  p_mem_add,
    input  logic [127:0] p_mem_data,
    output logic [31:0]  dq_instr,
    output logic [31:0]  dq_pc,
    output logic         dq_valid,
    input  logic         dq_ready,
    input  logic         br_valid,
    input  logic [31:0]  br_addr
);

    logic [27:0]          fetch_pc_q, fetch_pc_d;
    logic [OFF_W-1:0]     rd_off_q, rd_off_d;
    logic                 fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0] fifo_cnt;
    fetch_line_t          head, fill_line;
    logic                 fill_en, xfer, pop_line;
    logic                 unused_bits;

    assign p_mem_add = {fetch_pc_q, 4'b0000};
    assign fill_line = '{base: fetch_pc_q, data: p_mem_data};

    // A redirect cycle neither fills nor transfers; the flush takes precedence.
    assign fill_en  = !fifo_full && !br_valid;
    assign xfer     = dq_valid && dq_ready && !br_valid;
    assign pop_line = xfer && (rd_off_q == OFF_W'(LINE_WORDS - 1));

    line_fifo #(.DEPTH(DEPTH)) u_line_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (fill_en),
        .push_dat_i (fill_line),
        .pop_i      (pop_line),
        .flush_i    (br_valid),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_cnt),
        .head_o     (head)
    );

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_off_d   = rd_off_q;
        if (br_valid) begin
            fetch_pc_d = br_addr[31:4];
            rd_off_d   = br_addr[3:2];
        end else begin
            if (fill_en) fetch_pc_d = fetch_pc_q + 28'd1;
            // Offset wraps 3 -> 0 exactly when the head line is popped.
            if (xfer)    rd_off_d   = rd_off_q + OFF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC[31:4];
            rd_off_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_off_q   <= rd_off_d;
        end
    end

    assign dq_valid = !fifo_empty;
    assign dq_instr = dq_valid ? line_word(head.data, rd_off_q) : 32'h0;
    assign dq_pc    = dq_valid ? {head.base, rd_off_q, 2'b00} : 32'h0;

    assign unused_bits = ^{fifo_cnt, br_addr[1:0]};

endmodule
